// File: rtl/regm_wb_arbiter.sv
// regm_wb_arbiter: write-back scheduler for the single write port of regm.
// Two requesters (0: ALU path, 1: load/multi-cycle path) are arbitrated
// round-robin. The winning write is registered onto write/wrreg/wrdata, and
// writes to register 0 are suppressed. A 32-entry pending-write scoreboard
// lets issue logic stall on read-after-write hazards.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   rsv_valid, rsv_reg         reserve a destination register at issue
//   req0_valid/reg/data/ready  requester 0 handshake (ready combinational)
//   req1_valid/reg/data/ready  requester 1 handshake (ready combinational)
//   write, wrreg, wrdata       registered write port to regm
//   rd1_reg, rd2_reg           hazard query indices
//   rd1_busy, rd2_busy         scoreboard lookups (combinational)
//   busy_mask                  registered scoreboard, bit k = reg k pending
module regm_wb_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rsv_valid,
  input  logic [4:0]  rsv_reg,
  input  logic        req0_valid,
  input  logic [4:0]  req0_reg,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_reg,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        write,
  output logic [4:0]  wrreg,
  output logic [31:0] wrdata,
  input  logic [4:0]  rd1_reg,
  input  logic [4:0]  rd2_reg,
  output logic        rd1_busy,
  output logic        rd2_busy,
  output logic [31:0] busy_mask
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned NUM_REGS = 32;

  // 1 = requester 1 won the most recent transfer; reset to 1 so req0 wins first tie
  logic              last_grant;
  logic              grant0;
  logic              grant1;
  logic              transfer;
  logic [REG_W-1:0]  sel_reg;
  logic [DATA_W-1:0] sel_data;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] busy_next;

  // Round-robin grant: a lone requester always wins, a tie goes to the one not granted last
  always_comb begin
    grant0   = req0_valid && (!req1_valid || last_grant);
    grant1   = req1_valid && (!req0_valid || !last_grant);
    transfer = grant0 || grant1;
    sel_reg  = grant1 ? req1_reg  : req0_reg;
    sel_data = grant1 ? req1_data : req0_data;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Scoreboard update: clear on the commit edge, set on reservation; set wins on overlap
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (rsv_valid && (rsv_reg != REG_W'(0))) begin
      set_vec = NUM_REGS'(1) << rsv_reg;
    end
    if (write) begin
      clr_vec = NUM_REGS'(1) << wrreg;
    end
    busy_next = (busy_mask & ~clr_vec) | set_vec;
  end

  // Output register, grant history and scoreboard state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write      <= 1'b0;
      wrreg      <= '0;
      wrdata     <= '0;
      busy_mask  <= '0;
      last_grant <= 1'b1;
    end else begin
      busy_mask <= busy_next;
      if (transfer) begin
        write      <= (sel_reg != REG_W'(0));
        wrreg      <= sel_reg;
        wrdata     <= sel_data;
        last_grant <= grant1;
      end else begin
        write <= 1'b0;
      end
    end
  end

  // Hazard lookups see only the registered mask
  assign rd1_busy = busy_mask[rd1_reg];
  assign rd2_busy = busy_mask[rd2_reg];

endmodule

// File: tb/tb_regm_wb_arbiter.sv
// Directed bench for regm_wb_arbiter with a behavioural regm model on its write port.
module tb_regm_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        rsv_valid;
  logic [4:0]  rsv_reg;
  logic        req0_valid;
  logic [4:0]  req0_reg;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_reg;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic        write;
  logic [4:0]  wrreg;
  logic [31:0] wrdata;
  logic [4:0]  rd1_reg;
  logic [4:0]  rd2_reg;
  logic        rd1_busy;
  logic        rd2_busy;
  logic [31:0] busy_mask;

  int unsigned n_pass;
  int unsigned n_total;

  // regm model: 32x32, reg 0 reads 0
  logic [31:0] regm_mem [32];

  regm_wb_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rsv_valid  (rsv_valid),
    .rsv_reg    (rsv_reg),
    .req0_valid (req0_valid),
    .req0_reg   (req0_reg),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_reg   (req1_reg),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .write      (write),
    .wrreg      (wrreg),
    .wrdata     (wrdata),
    .rd1_reg    (rd1_reg),
    .rd2_reg    (rd2_reg),
    .rd1_busy   (rd1_busy),
    .rd2_busy   (rd2_busy),
    .busy_mask  (busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (write && (wrreg != 5'd0)) regm_mem[wrreg] <= wrdata;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rsv_valid  = 1'b0;
    rsv_reg    = 5'd0;
    req0_valid = 1'b0;
    req0_reg   = 5'd0;
    req0_data  = 32'd0;
    req1_valid = 1'b0;
    req1_reg   = 5'd0;
    req1_data  = 32'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  logic [4:0] r0;
  logic [4:0] r1;

  initial begin
    n_pass  = 0;
    n_total = 0;
    for (int i = 0; i < 32; i++) regm_mem[i] = 32'd0;
    rd1_reg = 5'd0;
    rd2_reg = 5'd0;
    idle_inputs();
    rst_n = 1'b0;
    #2;
    chk("reset_write",  {31'd0, write}, 32'd0);
    chk("reset_wrreg",  {27'd0, wrreg}, 32'd0);
    chk("reset_wrdata", wrdata, 32'd0);
    chk("reset_busy",   busy_mask, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;

    // Lone req0 write: reg 5 <= 50
    req0_valid = 1'b1; req0_reg = 5'd5; req0_data = 32'd50;
    #1;
    chk("solo_r0_ready", {31'd0, req0_ready}, 32'd1);
    chk("solo_r1_ready", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0;
    chk("solo_write",  {31'd0, write}, 32'd1);
    chk("solo_wrreg",  {27'd0, wrreg}, 32'd5);
    chk("solo_wrdata", wrdata, 32'd50);
    tick();
    chk("solo_idle_write", {31'd0, write}, 32'd0);
    chk("solo_wrreg_hold", {27'd0, wrreg}, 32'd5);
    chk("solo_regm5", regm_mem[5], 32'd50);

    // Continuous contention from reset: grants 0,1,0,1
    do_reset();
    r0 = 5'd1;
    r1 = 5'd11;
    for (int i = 0; i < 4; i++) begin
      req0_valid = 1'b1; req0_reg = r0; req0_data = 32'(r0) * 32'd10;
      req1_valid = 1'b1; req1_reg = r1; req1_data = 32'(r1) * 32'd10;
      #1;
      chk("rr_r0_ready", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_r1_ready", {31'd0, req1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      chk("rr_wrreg", {27'd0, wrreg}, (i % 2 == 0) ? 32'(r0) : 32'(r1));
      if (i % 2 == 0) r0 = r0 + 5'd1;
      else            r1 = r1 + 5'd1;
    end
    idle_inputs();
    tick();
    chk("rr_regm1",  regm_mem[1],  32'd10);
    chk("rr_regm11", regm_mem[11], 32'd110);
    chk("rr_regm2",  regm_mem[2],  32'd20);
    chk("rr_regm12", regm_mem[12], 32'd120);
    chk("rr_regm3",  regm_mem[3],  32'd0);

    // req0 write to set last_grant=0, then req1 writes reg 0
    req0_valid = 1'b1; req0_reg = 5'd6; req0_data = 32'd60;
    tick();
    idle_inputs();
    req1_valid = 1'b1; req1_reg = 5'd0; req1_data = 32'hFFFF_FFFF;
    #1;
    chk("r0w_r1_ready", {31'd0, req1_ready}, 32'd1);
    tick();
    idle_inputs();
    chk("r0w_write",  {31'd0, write}, 32'd0);
    chk("r0w_wrdata", wrdata, 32'hFFFF_FFFF);
    chk("r0w_busy0",  busy_mask, 32'd0);
    tick();
    chk("r0w_regm0", regm_mem[0], 32'd0);
    chk("r0w_regm6", regm_mem[6], 32'd60);
    req0_valid = 1'b1; req0_reg = 5'd20; req0_data = 32'd200;
    req1_valid = 1'b1; req1_reg = 5'd21; req1_data = 32'd210;
    #1;
    chk("r0w_tie_r0", {31'd0, req0_ready}, 32'd1);
    chk("r0w_tie_r1", {31'd0, req1_ready}, 32'd0);
    tick();
    idle_inputs();
    tick();

    // Reserve reg 7, then commit a write of 70
    rd1_reg = 5'd7;
    rd2_reg = 5'd7;
    rsv_valid = 1'b1; rsv_reg = 5'd7;
    #1;
    chk("rsv7_no_fwd", {31'd0, rd1_busy}, 32'd0);
    tick();
    rsv_valid = 1'b0;
    chk("rsv7_rd1", {31'd0, rd1_busy}, 32'd1);
    chk("rsv7_rd2", {31'd0, rd2_busy}, 32'd1);
    chk("rsv7_mask", busy_mask, 32'h0000_0080);
    req0_valid = 1'b1; req0_reg = 5'd7; req0_data = 32'd70;
    tick();
    idle_inputs();
    chk("wr7_write", {31'd0, write}, 32'd1);
    chk("wr7_busy_pre", {31'd0, rd1_busy}, 32'd1);
    tick();
    chk("wr7_busy_post", {31'd0, rd1_busy}, 32'd0);
    chk("wr7_regm7", regm_mem[7], 32'd70);

    // Reservation overlapping the commit of the same register keeps it busy
    rsv_valid = 1'b1; rsv_reg = 5'd9;
    tick();
    rsv_valid = 1'b0;
    req0_valid = 1'b1; req0_reg = 5'd9; req0_data = 32'd90;
    tick();
    idle_inputs();
    rsv_valid = 1'b1; rsv_reg = 5'd9;
    tick();
    rsv_valid = 1'b0;
    chk("ovl_busy9", busy_mask, 32'h0000_0200);
    rsv_valid = 1'b1; rsv_reg = 5'd0;
    tick();
    rsv_valid = 1'b0;
    chk("rsv0_ignored", busy_mask, 32'h0000_0200);

    // Reset mid-cycle drops an in-flight write and all reservations
    do_reset();
    rsv_valid = 1'b1; rsv_reg = 5'd3;
    tick();
    rsv_reg = 5'd8;
    tick();
    rsv_valid = 1'b0;
    chk("pre_rst_mask", busy_mask, 32'h0000_0108);
    req0_valid = 1'b1; req0_reg = 5'd3; req0_data = 32'd33;
    tick();
    idle_inputs();
    chk("pre_rst_write", {31'd0, write}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_write", {31'd0, write}, 32'd0);
    chk("mid_rst_busy",  busy_mask, 32'd0);
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_reg = 5'd4; req0_data = 32'd40;
    req1_valid = 1'b1; req1_reg = 5'd14; req1_data = 32'd140;
    #1;
    chk("post_rst_tie_r0", {31'd0, req0_ready}, 32'd1);
    chk("post_rst_tie_r1", {31'd0, req1_ready}, 32'd0);
    tick();
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
